exec_ctrl: RTL and testbench
============================

// Module: exec_ctrl
// PURPOSE
//   Run/step/pause sequencer for the single-cycle Y86-64 core. Drives cpu_en, which gates
//   every architectural write (PC, register file, CC, data memory). Watches the status code
//   from the status unit and stops the core on HLT/ADR/INS. Latches the final status and
//   keeps retired-instruction and active-cycle counters for the bench and the debug host.
// PARAMETERS
//   CNT_W        32    width of the retired and cycles counters
//   WDOG_CYCLES  1024  enabled-cycle budget per run; used only when EXEC_WDOG_EN is defined
// PORTS
//   clk       in   1      core clock; all state updates on its rising edge
//   rst_n     in   1      synchronous, active-low reset
//   run_req   in   1      request free-running execution (level or pulse)
//   step_req  in   1      request execution of exactly one instruction
//   halt_req  in   1      request pause after the current instruction
//   stat_in   in   3      status of the instruction executing this cycle: 1 AOK, 2 HLT, 3 ADR, 4 INS
//   cpu_en    out  1      core write enable; high only in RUN and STEP
//   state     out  3      current FSM state, encoded per exec_ctrl_pkg
//   stat_out  out  3      latched final status; 1 while the core is not stopped
//   done      out  1      one-cycle pulse on the cycle after entry to STOP
//   retired   out  CNT_W  count of enabled cycles that ended with stat_in == AOK; saturates
//   cycles    out  CNT_W  count of cycles spent in RUN, STEP or PAUSE; saturates
// BEHAVIOUR
//   Reset (rst_n == 0 at an edge): state = IDLE, cpu_en = 0, stat_out = 1, done = 0,
//     retired = 0, cycles = 0. Reset overrides everything, including mid-RUN and STOP.
//   States: IDLE, RUN, STEP, PAUSE, STOP. cpu_en is a combinational decode of the state.
//   IDLE/PAUSE: run_req -> RUN; else step_req -> STEP; else hold. run_req beats step_req.
//   RUN:   each cycle executes one instruction. At the edge: stat_in != 1 -> STOP;
//          else halt_req -> PAUSE; else stay in RUN. A fault beats halt_req.
//   STEP:  executes for exactly one cycle. At the edge: stat_in != 1 -> STOP; else PAUSE.
//          step_req held high produces one step every 2 cycles (STEP, PAUSE, STEP, ...).
//   STOP:  sticky until reset. All requests are ignored. cpu_en = 0. Counters are frozen.
//   stat_in is sampled only at edges that end an enabled cycle; it is ignored in other states.
//   On entry to STOP, stat_out <= stat_in. Illegal codes (0 or 5-7) are latched as 4 (INS).
//   HLT counts as not retired. The halting instruction does not increment retired.
//   done: registered, high for exactly the first cycle in STOP.
//   Counters: both saturate at {CNT_W{1'b1}} and never wrap.
//     cycles increments on every edge at which the current state is RUN, STEP or PAUSE.
//   Latency: a request sampled at edge N gives cpu_en = 1 in cycle N+1.
// CONFIGURATION
//   EXEC_WDOG_EN defined: a watchdog counts enabled cycles.
//     It clears on every IDLE/PAUSE -> RUN or STEP transition.
//     When the count reaches WDOG_CYCLES with stat_in == 1: -> STOP, stat_out = 5 (TMO), done pulses.
//     A real fault on the same edge wins, and its code is latched.
//   EXEC_WDOG_EN undefined: no watchdog logic. stat_out is never 5.
// STRUCTURE
//   exec_ctrl_pkg: state encodings (IDLE..STOP) and status codes STAT_AOK/HLT/ADR/INS/TMO.
//   Sub-module exec_sat_cnt (parameter W; inputs clk, rst_n, inc; output q) is saturating.
//   It is instanced for retired, cycles and the watchdog.
// TESTING
//   1 Reset, run_req pulse, stat_in = 1 for 5 cycles, then 2 -> STOP; stat_out = 2; retired = 5;
//     done high for 1 cycle; cpu_en low.
//   2 step_req pulse x3 with stat_in = 1 -> each gives exactly 1 cpu_en cycle; retired = 3;
//     state ends in PAUSE.
//   3 RUN with halt_req and stat_in = 3 on the same edge -> STOP, stat_out = 3 (fault beats halt).
//   4 stat_in = 6 during STEP -> STOP, stat_out = 4. Later run_req and step_req are ignored.
//   5 rst_n low for 1 cycle mid-RUN -> IDLE, all outputs at reset values next cycle.
//   6 EXEC_WDOG_EN, WDOG_CYCLES = 8, stat_in held at 1 -> STOP after 8 enabled cycles, stat_out = 5.
//     CNT_W = 4 run of 20 cycles -> retired saturates at 15.

Source files
------------

// File: rtl/exec_ctrl_pkg.sv
// exec_ctrl_pkg
//   Shared definitions for the run/step/pause sequencer:
//     - state_t    : FSM state encodings, also exported on exec_ctrl.state
//     - STAT_*     : Y86-64 status codes seen on stat_in / latched on stat_out
//     - fault_code : maps a non-AOK status to the code latched on entry to STOP
package exec_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_STEP  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_STOP  = 3'd4
    } state_t;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;
    localparam logic [2:0] STAT_TMO = 3'd5;

    // Real fault codes pass through; anything undefined (0, 5-7) is
    // reported as an invalid instruction.
    function automatic logic [2:0] fault_code(input logic [2:0] s);
        case (s)
            STAT_HLT, STAT_ADR, STAT_INS: fault_code = s;
            default:                      fault_code = STAT_INS;
        endcase
    endfunction

endpackage

// File: rtl/exec_ctrl_sat_cnt.sv
// exec_sat_cnt
//   Saturating up-counter: increments on inc, sticks at all-ones.
//   Ports:
//     clk   in  1  clock
//     rst_n in  1  synchronous active-low clear
//     inc   in  1  increment request
//     q     out W  count value
module exec_sat_cnt #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] q_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_reg <= '0;
        end else if (inc && (q_reg != {W{1'b1}})) begin
            q_reg <= q_reg + 1'b1;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/exec_ctrl.sv
// exec_ctrl
//   Run/step/pause sequencer for the single-cycle Y86-64 core. cpu_en gates
//   every architectural write; the FSM stops the core on any non-AOK status
//   and keeps retired-instruction and active-cycle counters.
//   Optional feature: define EXEC_WDOG_EN to add an enabled-cycle watchdog
//   that stops a run after WDOG_CYCLES enabled cycles with status TMO (5).
//   Ports:
//     clk, rst_n                    clock, synchronous active-low reset
//     run_req, step_req, halt_req   execution requests
//     stat_in  [2:0]                status of the instruction executing now
//     cpu_en                        core write enable (RUN or STEP)
//     state    [2:0]                current FSM state (state_t encoding)
//     stat_out [2:0]                latched final status, 1 until stopped
//     done                          pulse in the first STOP cycle
//     retired  [CNT_W-1:0]          AOK enabled cycles, saturating
//     cycles   [CNT_W-1:0]          cycles in RUN/STEP/PAUSE, saturating
module exec_ctrl
    import exec_ctrl_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int WDOG_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run_req,
    input  logic             step_req,
    input  logic             halt_req,
    input  logic [2:0]       stat_in,
    output logic             cpu_en,
    output logic [2:0]       state,
    output logic [2:0]       stat_out,
    output logic             done,
    output logic [CNT_W-1:0] retired,
    output logic [CNT_W-1:0] cycles
);

    state_t     state_reg, state_next;
    logic [2:0] stat_reg, stat_next;
    logic       done_reg;
    logic       fault;
    logic       timeout;

    assign cpu_en = (state_reg == ST_RUN) || (state_reg == ST_STEP);
    assign fault  = (stat_in != STAT_AOK);

`ifdef EXEC_WDOG_EN
    localparam int              WDOG_W    = $clog2(WDOG_CYCLES + 1);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

    logic [WDOG_W-1:0] wdog_q;
    logic              wdog_clr;
    logic              wdog_rst_n;

    // Launch from IDLE/PAUSE restarts the budget. Derived from the request
    // inputs rather than state_next so there is no loop through timeout.
    assign wdog_clr   = ((state_reg == ST_IDLE) || (state_reg == ST_PAUSE)) &&
                        (run_req || step_req);
    assign wdog_rst_n = rst_n && !wdog_clr;

    exec_sat_cnt #(.W(WDOG_W)) u_wdog (
        .clk   (clk),
        .rst_n (wdog_rst_n),
        .inc   (cpu_en),
        .q     (wdog_q)
    );

    // wdog_q counts enabled cycles already completed, so the cycle ending
    // at this edge is the WDOG_CYCLES-th when wdog_q == WDOG_CYCLES-1.
    assign timeout = cpu_en && (wdog_q >= WDOG_LAST);
`else
    logic unused_wdog;
    assign unused_wdog = (WDOG_CYCLES == 0);
    assign timeout     = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        stat_next  = stat_reg;
        case (state_reg)
            ST_IDLE, ST_PAUSE: begin
                if (run_req)       state_next = ST_RUN;
                else if (step_req) state_next = ST_STEP;
            end
            ST_RUN, ST_STEP: begin
                // A real fault wins over both the watchdog and halt_req.
                if (fault) begin
                    state_next = ST_STOP;
                    stat_next  = fault_code(stat_in);
                end else if (timeout) begin
                    state_next = ST_STOP;
                    stat_next  = STAT_TMO;
                end else if ((state_reg == ST_STEP) || halt_req) begin
                    state_next = ST_PAUSE;
                end
            end
            ST_STOP: state_next = ST_STOP;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            stat_reg  <= STAT_AOK;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            stat_reg  <= stat_next;
            done_reg  <= (state_next == ST_STOP) && (state_reg != ST_STOP);
        end
    end

    // Counter 0: retired instructions; counter 1: active cycles.
    // Both stop naturally in STOP since neither increment is asserted there.
    logic [1:0]       cnt_inc;
    logic [CNT_W-1:0] cnt_q [2];

    assign cnt_inc[0] = cpu_en && (stat_in == STAT_AOK);
    assign cnt_inc[1] = cpu_en || (state_reg == ST_PAUSE);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            exec_sat_cnt #(.W(CNT_W)) u_cnt (
                .clk   (clk),
                .rst_n (rst_n),
                .inc   (cnt_inc[gi]),
                .q     (cnt_q[gi])
            );
        end
    endgenerate

    assign state    = state_reg;
    assign stat_out = stat_reg;
    assign done     = done_reg;
    assign retired  = cnt_q[0];
    assign cycles   = cnt_q[1];

endmodule

// File: tb/tb_exec_ctrl.sv
module tb_exec_ctrl;
    import exec_ctrl_pkg::*;

    localparam int CNT_W = 4;
    localparam int WDOG  = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef EXEC_WDOG_EN
    localparam bit WDOG_ON = 1'b1;
`else
    localparam bit WDOG_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n, run_req, step_req, halt_req;
    logic [2:0]       stat_in;
    logic             cpu_en, done;
    logic [2:0]       state, stat_out;
    logic [CNT_W-1:0] retired, cycles;

    exec_ctrl #(.CNT_W(CNT_W), .WDOG_CYCLES(WDOG)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .run_req  (run_req),
        .step_req (step_req),
        .halt_req (halt_req),
        .stat_in  (stat_in),
        .cpu_en   (cpu_en),
        .state    (state),
        .stat_out (stat_out),
        .done     (done),
        .retired  (retired),
        .cycles   (cycles)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Behavioural reference: what the sequencer should be doing, tracked as
    // "mode" plus counts of events since reset / since the last launch.
    int m_state, m_stat, m_done, m_ret, m_cyc, m_launch_en;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string name, input int e_state, input int e_en,
                             input int e_stat, input int e_done, input int e_ret,
                             input int e_cyc);
        check({name, ".state"},    int'(state),    e_state);
        check({name, ".cpu_en"},   int'(cpu_en),   e_en);
        check({name, ".stat_out"}, int'(stat_out), e_stat);
        check({name, ".done"},     int'(done),     e_done);
        check({name, ".retired"},  int'(retired),  e_ret);
        check({name, ".cycles"},   int'(cycles),   e_cyc);
    endtask

    function automatic int stop_code(input int s);
        return (s >= 2 && s <= 4) ? s : 4;
    endfunction

    // Advance the reference by one edge using the inputs presently applied.
    task automatic model_edge();
        bit executing;
        if (!rst_n) begin
            m_state = ST_IDLE; m_stat = 1; m_done = 0; m_ret = 0; m_cyc = 0; m_launch_en = 0;
            return;
        end
        executing = (m_state == ST_RUN) || (m_state == ST_STEP);
        if (executing && stat_in == 3'd1) m_ret = (m_ret < CMAX) ? m_ret + 1 : CMAX;
        if (executing || m_state == ST_PAUSE) m_cyc = (m_cyc < CMAX) ? m_cyc + 1 : CMAX;
        m_done = 0;
        if (m_state == ST_IDLE || m_state == ST_PAUSE) begin
            if (run_req || step_req) begin
                m_state     = run_req ? ST_RUN : ST_STEP;
                m_launch_en = 0;
            end
        end else if (executing) begin
            m_launch_en++;
            if (stat_in != 3'd1) begin
                m_state = ST_STOP; m_stat = stop_code(int'(stat_in)); m_done = 1;
            end else if (WDOG_ON && m_launch_en >= WDOG) begin
                m_state = ST_STOP; m_stat = 5; m_done = 1;
            end else if (m_state == ST_STEP || halt_req) begin
                m_state = ST_PAUSE;
            end
        end
    endtask

    task automatic cyc();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic set(input bit r, input bit run, input bit stp, input bit hlt, input int s);
        rst_n = r; run_req = run; step_req = stp; halt_req = hlt; stat_in = 3'(s);
    endtask

    task automatic reset_dut();
        set(0, 0, 0, 0, 1); cyc();
        set(1, 0, 0, 0, 1);
    endtask

    typedef struct {
        bit r, run, stp, hlt;
        int s;
        int e_state, e_en, e_stat, e_done, e_ret, e_cyc;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int en_cnt;
        set(1, 0, 0, 0, 1);
        #1;

        // Run 5 AOK instructions, then HLT; later requests are ignored.
        tbl[0] = '{0, 0, 0, 0, 1, ST_IDLE, 0, 1, 0, 0, 0};
        tbl[1] = '{1, 1, 0, 0, 1, ST_RUN,  1, 1, 0, 0, 0};
        tbl[2] = '{1, 0, 0, 0, 1, ST_RUN,  1, 1, 0, 1, 1};
        tbl[3] = '{1, 0, 0, 0, 1, ST_RUN,  1, 1, 0, 2, 2};
        tbl[4] = '{1, 0, 0, 0, 1, ST_RUN,  1, 1, 0, 3, 3};
        tbl[5] = '{1, 0, 0, 0, 1, ST_RUN,  1, 1, 0, 4, 4};
        tbl[6] = '{1, 0, 0, 0, 1, ST_RUN,  1, 1, 0, 5, 5};
        tbl[7] = '{1, 0, 0, 0, 2, ST_STOP, 0, 2, 1, 5, 6};
        tbl[8] = '{1, 1, 0, 0, 1, ST_STOP, 0, 2, 0, 5, 6};
        tbl[9] = '{1, 0, 1, 1, 3, ST_STOP, 0, 2, 0, 5, 6};
        for (int i = 0; i < 10; i++) begin
            set(tbl[i].r, tbl[i].run, tbl[i].stp, tbl[i].hlt, tbl[i].s);
            cyc();
            check_all($sformatf("tbl%0d", i), tbl[i].e_state, tbl[i].e_en, tbl[i].e_stat,
                      tbl[i].e_done, tbl[i].e_ret, tbl[i].e_cyc);
            $display("vec %0d: state=%0d en=%0d stat=%0d done=%0d ret=%0d cyc=%0d",
                     i, state, cpu_en, stat_out, done, retired, cycles);
        end

        // Three step pulses: one enabled cycle each, ending in PAUSE.
        reset_dut();
        en_cnt = 0;
        for (int k = 0; k < 3; k++) begin
            set(1, 0, 1, 0, 1); cyc(); en_cnt += int'(cpu_en);
            set(1, 0, 0, 0, 1); cyc(); en_cnt += int'(cpu_en);
            cyc(); en_cnt += int'(cpu_en);
        end
        check("step3.en_cycles", en_cnt, 3);
        check("step3.retired", int'(retired), 3);
        check("step3.cycles", int'(cycles), 8);
        check("step3.state", int'(state), ST_PAUSE);
        $display("step x3: en_cycles=%0d retired=%0d state=%0d", en_cnt, retired, state);

        // step_req held: STEP, PAUSE, STEP, PAUSE.
        set(1, 0, 1, 0, 1);
        for (int k = 0; k < 4; k++) begin
            cyc();
            check($sformatf("step_held%0d.en", k), int'(cpu_en), (k % 2 == 0) ? 1 : 0);
        end
        $display("step held: retired=%0d", retired);

        // halt_req alone pauses; fault together with halt_req stops.
        reset_dut();
        set(1, 1, 0, 0, 1); cyc();
        set(1, 0, 0, 1, 1); cyc();
        check("halt.state", int'(state), ST_PAUSE);
        set(1, 1, 0, 0, 1); cyc();
        set(1, 0, 0, 1, 3); cyc();
        check_all("halt_fault", ST_STOP, 0, 3, 1, 1, 3);
        set(1, 0, 0, 0, 1); cyc();
        check("halt_fault.done_drop", int'(done), 0);
        $display("halt vs fault: stat_out=%0d state=%0d", stat_out, state);

        // Illegal code during STEP latches INS; STOP ignores requests.
        reset_dut();
        set(1, 0, 1, 0, 1); cyc();
        set(1, 0, 0, 0, 6); cyc();
        check_all("illegal", ST_STOP, 0, 4, 1, 0, 1);
        set(1, 1, 1, 0, 1);
        for (int k = 0; k < 3; k++) begin
            cyc();
            check_all($sformatf("stop_hold%0d", k), ST_STOP, 0, 4, 0, 0, 1);
        end
        $display("illegal stat: stat_out=%0d state=%0d", stat_out, state);

        // Reset mid-RUN.
        reset_dut();
        set(1, 1, 0, 0, 1); cyc();
        set(1, 0, 0, 0, 1); cyc(); cyc(); cyc();
        set(0, 1, 0, 0, 2); cyc();
        check_all("rst_mid_run", ST_IDLE, 0, 1, 0, 0, 0);
        set(1, 0, 0, 0, 1); cyc();
        check("rst_mid_run.idle", int'(state), ST_IDLE);
        $display("reset mid-run: state=%0d retired=%0d", state, retired);

        // Counter saturation through 20 step pulses.
        reset_dut();
        for (int k = 0; k < 20; k++) begin
            set(1, 0, 1, 0, 1); cyc();
            set(1, 0, 0, 0, 1); cyc();
        end
        check("sat_step.retired", int'(retired), CMAX);
        check("sat_step.cycles", int'(cycles), CMAX);
        check("sat_step.state", int'(state), ST_PAUSE);
        $display("saturation (steps): retired=%0d cycles=%0d", retired, cycles);

`ifdef EXEC_WDOG_EN
        // Watchdog: held AOK stops after WDOG enabled cycles.
        reset_dut();
        set(1, 1, 0, 0, 1); cyc();
        set(1, 0, 0, 0, 1);
        en_cnt = 0;
        for (int i = 0; i < 50 && state != ST_STOP; i++) begin
            en_cnt += int'(cpu_en);
            cyc();
        end
        check("wdog.state", int'(state), ST_STOP);
        check("wdog.en_cycles", en_cnt, WDOG);
        check("wdog.stat_out", int'(stat_out), 5);
        check("wdog.done", int'(done), 1);
        $display("watchdog: en_cycles=%0d stat_out=%0d", en_cnt, stat_out);

        // Real fault on the timeout edge wins.
        reset_dut();
        set(1, 1, 0, 0, 1); cyc();
        set(1, 0, 0, 0, 1);
        for (int k = 0; k < WDOG - 1; k++) cyc();
        set(1, 0, 0, 0, 3); cyc();
        check("wdog_fault.stat_out", int'(stat_out), 3);

        // Pause/resume restarts the budget.
        reset_dut();
        set(1, 1, 0, 0, 1); cyc();
        set(1, 0, 0, 0, 1); for (int k = 0; k < 5; k++) cyc();
        set(1, 0, 0, 1, 1); cyc();
        set(1, 1, 0, 0, 1); cyc();
        set(1, 0, 0, 0, 1); for (int k = 0; k < WDOG - 1; k++) cyc();
        check("wdog_resume.running", int'(state), ST_RUN);
        cyc();
        check("wdog_resume.stop", int'(stat_out), 5);
        $display("watchdog resume: state=%0d stat_out=%0d", state, stat_out);
`else
        // Long run saturates retired; no watchdog stops it.
        reset_dut();
        set(1, 1, 0, 0, 1); cyc();
        set(1, 0, 0, 0, 1);
        for (int k = 0; k < 20; k++) cyc();
        check("sat_run.retired", int'(retired), CMAX);
        check("sat_run.state", int'(state), ST_RUN);
        $display("saturation (run): retired=%0d state=%0d", retired, state);
`endif

        // Randomised stimulus against the reference.
        reset_dut();
        for (int i = 0; i < 3000; i++) begin
            set(($urandom_range(0, 39) != 0),
                ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 5) == 0),
                ($urandom_range(0, 5) == 0),
                ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 7)) : 1);
            cyc();
            check_all("rand", m_state, (m_state == ST_RUN || m_state == ST_STEP) ? 1 : 0,
                      m_stat, m_done, m_ret, m_cyc);
            if (i % 500 == 0)
                $display("rand %0d: state=%0d stat=%0d ret=%0d cyc=%0d",
                         i, state, stat_out, retired, cycles);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
